// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default data memory size.
package lsu_pkg;

   localparam int MEM_BYTES_DEFAULT = 4096;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: picks and extends the addressed byte/half of a
// memory word for loads, and splices store data into that word for stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        is_unsigned,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_word[{lane, 3'b000} +: 8];
      half_sel = mem_word[{lane[1], 4'b0000} +: 16];

      load_data   = mem_word;
      merged_word = mem_word;

      // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
      case (size)
         SZ_BYTE: begin
            load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
         end
         SZ_HALF: begin
            load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            merged_word[{lane[1], 4'b0000} +: 16] = store_data[15:0];
         end
         SZ_WORD: begin
            load_data   = mem_word;
            merged_word = store_data;
         end
         default: begin
            load_data   = mem_word;
            merged_word = mem_word;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-wide data memory: one request
// per transaction, sub-word stores done as read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   lsu_state_t  state;
   logic        lat_write;
   logic        lat_unsigned;
   logic [1:0]  lat_size;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic        req_err;
   logic        accept;

   assign accept = req_valid && req_ready;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if ({1'b0, req_addr} >= MEM_LIMIT) req_err = 1'b1;
   end

   lsu_lane_align u_align (
      .size        (lat_size),
      .lane        (lat_addr[1:0]),
      .is_unsigned (lat_unsigned),
      .mem_word    (dmem_rdata),
      .store_data  (lat_wdata),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // All outputs are registered; the memory read data is consumed in RD,
   // either extended into the response or merged into the store word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= 32'h0;
         dmem_read    <= 1'b0;
         dmem_write   <= 1'b0;
         dmem_addr    <= 32'h0;
         dmem_wdata   <= 32'h0;
         lat_write    <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_size     <= 2'b00;
         lat_addr     <= 32'h0;
         lat_wdata    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_write    <= req_write;
                  lat_unsigned <= req_unsigned;
                  lat_size     <= req_size;
                  lat_addr     <= req_addr;
                  lat_wdata    <= req_wdata;
                  req_ready    <= 1'b0;
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else if (req_write && req_size == SZ_WORD) begin
                     state      <= WR;
                     dmem_write <= 1'b1;
                     dmem_addr  <= {req_addr[31:2], 2'b00};
                     dmem_wdata <= req_wdata;
                  end else begin
                     state     <= RD;
                     dmem_read <= 1'b1;
                     dmem_addr <= {req_addr[31:2], 2'b00};
                  end
               end
            end
            RD: begin
               dmem_read <= 1'b0;
               if (lat_write) begin
                  state      <= WR;
                  dmem_write <= 1'b1;
                  dmem_addr  <= {lat_addr[31:2], 2'b00};
                  dmem_wdata <= merged_word;
               end else begin
                  state      <= RESP;
                  dmem_addr  <= 32'h0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end
            end
            WR: begin
               state      <= RESP;
               dmem_write <= 1'b0;
               dmem_addr  <= 32'h0;
               dmem_wdata <= 32'h0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'h0;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'h0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-wide memory model
// and hand-computed expected results.
module tb_load_store_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        dmem_read;
   logic        dmem_write;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;

   logic [31:0] mem [0:1023];
   logic        mem_clear;
   int          rd_count;
   int          wr_count;
   int          overlap_count;
   int          check_count;
   int          pass_count;

   load_store_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .dmem_read    (dmem_read),
      .dmem_write   (dmem_write),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dmem_rdata = mem[dmem_addr[11:2]];

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      end else if (dmem_write) begin
         mem[dmem_addr[11:2]] <= dmem_wdata;
      end
      if (dmem_read) rd_count <= rd_count + 1;
      if (dmem_write) wr_count <= wr_count + 1;
   end

   always @(negedge clk) begin
      if (rst_n && dmem_read && dmem_write) overlap_count <= overlap_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      else
         pass_count++;
   endtask

   // One full transaction; hold keeps resp_ready low that many cycles in RESP.
   task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input int hold, output logic [31:0] rdata, output logic err,
                                output int lat);
      int k;
      logic [31:0] held;
      rdata = 32'h0;
      err   = 1'b0;
      lat   = 0;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
         return;
      end
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) begin
         checkOutput({tag, "_resp_timeout"}, 32'd0, 32'd1);
         return;
      end
      rdata = resp_rdata;
      err   = resp_err;
      held  = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, {31'h0, resp_valid}, 32'd1);
         checkOutput({tag, "_hold_rdata"}, resp_rdata, held);
         checkOutput({tag, "_hold_req_ready"}, {31'h0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      if (hold > 0) begin
         checkOutput({tag, "_idle_req_ready"}, {31'h0, req_ready}, 32'd1);
         checkOutput({tag, "_idle_resp_valid"}, {31'h0, resp_valid}, 32'd0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, {31'h0, req_ready}, 32'd1);
      checkOutput({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd0);
      checkOutput({tag, "_resp_err"}, {31'h0, resp_err}, 32'd0);
      checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      checkOutput({tag, "_dmem_read"}, {31'h0, dmem_read}, 32'd0);
      checkOutput({tag, "_dmem_write"}, {31'h0, dmem_write}, 32'd0);
      checkOutput({tag, "_dmem_addr"}, dmem_addr, 32'h0);
      checkOutput({tag, "_dmem_wdata"}, dmem_wdata, 32'h0);
   endtask

   typedef struct {
      string       tag;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          rd_before;
      int          wr_before;

      check_count   = 0;
      pass_count    = 0;
      rd_count      = 0;
      wr_count      = 0;
      overlap_count = 0;
      mem_clear     = 1'b1;
      rst_n         = 1'b0;
      req_valid     = 1'b0;
      req_write     = 1'b0;
      req_size      = 2'b00;
      req_unsigned  = 1'b0;
      req_addr      = 32'h0;
      req_wdata     = 32'h0;
      resp_ready    = 1'b0;

      repeat (3) @(posedge clk);
      #1 checkResetOutputs("reset");
      @(negedge clk);
      rst_n     = 1'b1;
      mem_clear = 1'b0;

      // tag, wr, size, uns, addr, wdata, expected rdata, err, latency
      vecs.push_back('{"st_word",     1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2});
      vecs.push_back('{"ld_word",     1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2});
      vecs.push_back('{"st_byte",     1'b1, 2'b00, 1'b0, 32'h11,   32'h123456AA, 32'h0,        1'b0, 3});
      vecs.push_back('{"ld_word_b",   1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADAAEF, 1'b0, 2});
      vecs.push_back('{"ld_byte_s",   1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'hFFFFFFAA, 1'b0, 2});
      vecs.push_back('{"ld_byte_u",   1'b0, 2'b00, 1'b1, 32'h11,   32'h0,        32'h000000AA, 1'b0, 2});
      vecs.push_back('{"st_half",     1'b1, 2'b01, 1'b0, 32'h12,   32'hFFFF8001, 32'h0,        1'b0, 3});
      vecs.push_back('{"ld_word_h",   1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h8001AAEF, 1'b0, 2});
      vecs.push_back('{"ld_half_s",   1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFF8001, 1'b0, 2});
      vecs.push_back('{"ld_half_u",   1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h00008001, 1'b0, 2});
      vecs.push_back('{"ld_half_lo",  1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'hFFFFAAEF, 1'b0, 2});
      vecs.push_back('{"ld_byte_b0",  1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0, 2});
      vecs.push_back('{"ld_byte_b3",  1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h00000080, 1'b0, 2});
      vecs.push_back('{"ld_top_word", 1'b0, 2'b10, 1'b0, 32'hFFC,  32'h0,        32'h00000000, 1'b0, 2});
      vecs.push_back('{"err_word",    1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        32'h0,        1'b1, 1});
      vecs.push_back('{"err_half",    1'b0, 2'b01, 1'b0, 32'h01,   32'h0,        32'h0,        1'b1, 1});
      vecs.push_back('{"err_size",    1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1, 1});
      vecs.push_back('{"err_range",   1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1, 1});
      vecs.push_back('{"err_st_half", 1'b1, 2'b01, 1'b0, 32'h13,   32'h5555,     32'h0,        1'b1, 1});

      foreach (vecs[i]) begin
         rd_before = rd_count;
         wr_before = wr_count;
         applyStimulus(vecs[i].tag, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                       vecs[i].wdata, 0, rdata, err, lat);
         checkOutput({vecs[i].tag, "_rdata"}, rdata, vecs[i].exp_rdata);
         checkOutput({vecs[i].tag, "_err"}, {31'h0, err}, {31'h0, vecs[i].exp_err});
         checkOutput({vecs[i].tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
         if (vecs[i].exp_err) begin
            checkOutput({vecs[i].tag, "_no_read"}, 32'(rd_count - rd_before), 32'd0);
            checkOutput({vecs[i].tag, "_no_write"}, 32'(wr_count - wr_before), 32'd0);
         end
      end
      checkOutput("mem_word_0x10", mem[4], 32'h8001AAEF);

      applyStimulus("backpressure", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, rdata, err, lat);
      checkOutput("backpressure_rdata", rdata, 32'h8001AAEF);

      // Reset while a byte store sits in WR: its write must never reach memory.
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'h11;
      req_wdata    = 32'h00000055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 checkOutput("rst_mid_in_wr", {31'h0, dmem_write}, 32'd1);
      wr_before = wr_count;
      rst_n = 1'b0;
      #1 checkResetOutputs("rst_mid");
      repeat (2) @(posedge clk);
      #1 checkOutput("rst_mid_no_write", 32'(wr_count - wr_before), 32'd0);
      checkOutput("rst_mid_mem_kept", mem[4], 32'h8001AAEF);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("post_rst_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rdata, err, lat);
      checkOutput("post_rst_ld_rdata", rdata, 32'h8001AAEF);
      checkOutput("post_rst_ld_err", {31'h0, err}, 32'd0);

      checkOutput("no_rd_wr_overlap", 32'(overlap_count), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
